// File: rtl/hist_read_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hist_read_seq_if : bank read port plus per-bin output stream          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface hist_read_seq_if #(
    parameter int COUNT_WIDTH = 24
);
    logic [3:0]               rd_sel;
    logic [3:0]               rd_addr;
    logic [COUNT_WIDTH-1:0]   rd_data;
    logic                     bin_valid;
    logic                     bin_ready;
    logic [7:0]               bin_index;
    logic [COUNT_WIDTH-1:0]   bin_count;
    logic [COUNT_WIDTH+7:0]   bin_cum;
    logic                     bin_last;

    modport master (
        output rd_sel,
        output rd_addr,
        input  rd_data,
        output bin_valid,
        input  bin_ready,
        output bin_index,
        output bin_count,
        output bin_cum,
        output bin_last
    );

    modport slave (
        input  rd_sel,
        input  rd_addr,
        output rd_data,
        input  bin_valid,
        output bin_ready,
        input  bin_index,
        input  bin_count,
        input  bin_cum,
        input  bin_last
    );
endinterface
`default_nettype wire

// File: rtl/hist_read_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hist_read_seq : walks all 256 histogram bins, streams count + cum sum |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hist_read_seq #(
    parameter int COUNT_WIDTH = 24,
    parameter int RD_LAT      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   hist_valid,
    hist_read_seq_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH+7:0] total_count
);

    localparam logic [1:0] c_LAT_LAST = 2'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [7:0]               r_index;
    logic [1:0]               r_lat_cnt;
    logic [7:0]               r_bin_index;
    logic [COUNT_WIDTH-1:0]   r_bin_count;
    logic [COUNT_WIDTH+7:0]   r_cum;
    logic [COUNT_WIDTH+7:0]   r_total;

    logic                     w_start_ok;
    logic                     w_sample;
    logic                     w_advance;
    logic                     w_finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort outranks both start (in IDLE) and bin_ready (in OUT).
    always_comb begin
        w_state_nxt   = r_state;
        w_start_ok    = 1'b0;
        w_sample      = 1'b0;
        w_advance     = 1'b0;
        w_finish      = 1'b0;
        busy          = (r_state != IDLE);
        done          = (r_state == FIN);
        bus.bin_valid = (r_state == OUT);
        bus.bin_last  = (r_state == OUT) && (r_bin_index == 8'hFF);
        case (r_state)
            IDLE: begin
                if (start && hist_valid && !abort) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_lat_cnt == c_LAT_LAST) begin
                    w_sample    = 1'b1;
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (bus.bin_ready) begin
                    if (r_index == 8'hFF) begin
                        w_finish    = 1'b1;
                        w_state_nxt = FIN;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = FETCH;
                    end
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index     <= 8'd0;
            r_lat_cnt   <= 2'd0;
            r_bin_index <= 8'd0;
            r_bin_count <= '0;
            r_cum       <= '0;
            r_total     <= '0;
        end else begin
            if (w_start_ok) begin
                r_index <= 8'd0;
            end else if (w_advance) begin
                r_index <= r_index + 8'd1;
            end

            // Counts FETCH cycles so rd_data is taken only once it has settled.
            if (w_start_ok || w_advance) begin
                r_lat_cnt <= 2'd0;
            end else if ((r_state == FETCH) && !w_sample) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end

            if (w_start_ok) begin
                r_cum <= '0;
            end else if (w_sample) begin
                r_cum <= r_cum + {{8{1'b0}}, bus.rd_data};
            end

            if (w_sample) begin
                r_bin_count <= bus.rd_data;
                r_bin_index <= r_index;
            end

            if (w_finish) begin
                r_total <= r_cum;
            end
        end
    end

    assign bus.rd_sel    = r_index[7:4];
    assign bus.rd_addr   = r_index[3:0];
    assign bus.bin_index = r_bin_index;
    assign bus.bin_count = r_bin_count;
    assign bus.bin_cum   = r_cum;
    assign total_count   = r_total;

endmodule
`default_nettype wire

// File: doc/hist_read_seq.md
HIST_READ_SEQ -- requirements
Module: hist_read_seq

Interface
REQ-001: Parameter COUNT_WIDTH, default 24: width of one histogram bin count.
REQ-002: Parameter RD_LAT, default 1, legal 0..2: cycles from a stable rd_sel/rd_addr to valid rd_data.
REQ-003: clk  input  1  sole clock, all state updates on rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: start  input  1  one-cycle request to read out all 256 bins.
REQ-006: abort  input  1  synchronous cancel of an in-progress readout.
REQ-007: hist_valid  input  1  high when every histogram bank has finished counting.
REQ-008: rd_sel  output  4  bank select, equals bin index [7:4].
REQ-009: rd_addr  output  4  address within bank, equals bin index [3:0].
REQ-010: rd_data  input  COUNT_WIDTH  count returned for rd_sel/rd_addr.
REQ-011: bin_valid  output  1  bin_index/bin_count/bin_cum are valid.
REQ-012: bin_ready  input  1  downstream accepts the current bin.
REQ-013: bin_index  output  8  bin number 0..255.
REQ-014: bin_count  output  COUNT_WIDTH  captured count of bin_index.
REQ-015: bin_cum  output  COUNT_WIDTH+8  running sum of counts of bins 0..bin_index inclusive.
REQ-016: bin_last  output  1  high with bin_valid when bin_index==255.
REQ-017: busy  output  1  high in any state other than IDLE.
REQ-018: done  output  1  one-cycle pulse after bin 255 is accepted.
REQ-019: total_count  output  COUNT_WIDTH+8  final sum of all 256 bins, held until next accepted start.

Function
REQ-020: FSM states shall be IDLE, FETCH, OUT, FIN.
REQ-021: In IDLE, start==1 and hist_valid==1 shall set index to 0, clear bin_cum accumulator, and enter FETCH next cycle.
REQ-022: start while busy, or with hist_valid==0, shall be ignored with no state change.
REQ-023: rd_sel/rd_addr shall be registered from index and stay constant for the whole FETCH and OUT stay of that index.
REQ-024: FETCH shall last exactly RD_LAT+1 cycles; rd_data shall be sampled on the clock edge ending the last FETCH cycle.
REQ-025: On that edge bin_count<=rd_data, bin_cum<=bin_cum+rd_data (zero-extended, no overflow possible), bin_index<=index, state<=OUT.
REQ-026: In OUT bin_valid shall be 1; bin_index/bin_count/bin_cum/bin_last shall stay stable while bin_valid&&!bin_ready.
REQ-027: bin_valid&&bin_ready with index<255 shall increment index and enter FETCH; bin_valid shall drop the next cycle.
REQ-028: bin_valid&&bin_ready with index==255 shall load total_count<=bin_cum and enter FIN.
REQ-029: FIN shall last one cycle with done=1, busy=1, then return to IDLE.
REQ-030: bin_valid shall never assert outside OUT; throughput is at most one bin per RD_LAT+2 cycles.
REQ-031: abort==1 in FETCH or OUT shall return to IDLE next cycle, drop bin_valid, not pulse done, and leave total_count unchanged; abort in IDLE/FIN is ignored; abort has priority over bin_ready in the same cycle.
REQ-032: start and abort asserted together in IDLE: start shall be ignored.
REQ-033: rd_data shall be ignored outside the sampling edge of REQ-024.

Reset
REQ-034: rst==1 shall immediately force IDLE, index=0, rd_sel=0, rd_addr=0, bin_valid=0, bin_index=0, bin_count=0, bin_cum=0, bin_last=0, busy=0, done=0, total_count=0, regardless of current state.
REQ-035: After rst deasserts the block shall accept start on the first rising edge where REQ-021 holds.

Verification
REQ-036: RD_LAT=1, model rd_data=bin index+1, bin_ready tied 1 -> 256 bins in order, bin_count 1..256, bin_last only at 255, total_count=32896, one done pulse, bin i issued every 3 cycles.
REQ-037: bin_ready random 30% duty -> outputs stable while stalled, same sequence and total_count=32896 as REQ-036.
REQ-038: All bins = 2^COUNT_WIDTH-1 (COUNT_WIDTH=24) -> total_count = 256*16777215 = 4294967040, no wrap.
REQ-039: abort asserted in OUT at bin 100 with bin_ready=1 -> IDLE next cycle, no done, total_count unchanged; fresh start reads from bin 0 with bin_cum restarted.
REQ-040: start while busy, and start with hist_valid=0 -> ignored; rst asserted mid-FETCH at bin 50 -> all outputs at reset values in the same cycle, done never pulses.
REQ-041: Repeat REQ-036 with RD_LAT=0 and RD_LAT=2 -> identical data, per-bin period 2 and 4 cycles.
